// File: rtl/mux_scan_feeder_pkg.sv
// Shared types and constants for the mux4x1 scan feeder and the mux benches.
// Scan start and end indices are derived from the mux width and the scan order.
package mux_scan_feeder_pkg;

    localparam int N_IN_DEF  = 4;
    localparam int SEL_W_DEF = 2;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t SCAN = 1'b1;

    function automatic int start_idx(input int n_in, input bit msb_first);
        return msb_first ? (n_in - 1) : 0;
    endfunction

    function automatic int end_idx(input int n_in, input bit msb_first);
        return msb_first ? 0 : (n_in - 1);
    endfunction

endpackage

// File: rtl/mux_scan_feeder_if.sv
// Word-in / bit-out handshake bundle, plus the loop through the external mux.
// The slave view belongs to the feeder; the master view belongs to the environment.
interface mux_scan_feeder_if #(
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
);
    logic              in_valid;
    logic [N_IN-1:0]   in_data;
    logic              in_ready;
    logic [N_IN-1:0]   mux_din;
    logic [SEL_W-1:0]  mux_sel;
    logic              mux_dout;
    logic              out_valid;
    logic              out_bit;
    logic              out_last;
    logic              out_ready;
    logic              busy;

    modport slave (
        input  in_valid, in_data, mux_dout, out_ready,
        output in_ready, mux_din, mux_sel, out_valid, out_bit, out_last, busy
    );

    modport master (
        output in_valid, in_data, mux_dout, out_ready,
        input  in_ready, mux_din, mux_sel, out_valid, out_bit, out_last, busy
    );
endinterface

// File: rtl/mux_scan_feeder_scan_sel_counter.sv
// Loadable up/down select counter; saturates at the end index so the select
// only ever returns to the start through an explicit load.
module scan_sel_counter
    import mux_scan_feeder_pkg::*;
#(
    parameter int N_IN      = N_IN_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             term_o
);

    localparam logic [SEL_W-1:0] START_SEL = SEL_W'(start_idx(N_IN, MSB_FIRST));
    localparam logic [SEL_W-1:0] END_SEL   = SEL_W'(end_idx(N_IN, MSB_FIRST));

    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    assign term_o = (sel_q == END_SEL);
    assign sel_o  = sel_q;

    always_comb begin
        sel_d = sel_q;
        if (load_i) begin
            sel_d = START_SEL;
        end else if (en_i && !term_o) begin
            sel_d = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/mux_scan_feeder.sv
// Serialises 4-bit words through an external mux4x1: holds the word on mux_din,
// steps mux_sel once per accepted output beat and forwards mux_dout downstream.
module mux_scan_feeder
    import mux_scan_feeder_pkg::*;
#(
    parameter int N_IN      = N_IN_DEF,
    parameter int SEL_W     = SEL_W_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_scan_feeder_if.slave  bus
);

    state_t          state_q;
    state_t          state_d;
    logic [N_IN-1:0] din_q;
    logic [N_IN-1:0] din_d;

    logic scanning;
    logic last_beat;
    logic in_ready;
    logic accept_in;
    logic beat;
    logic sel_term;

    assign scanning  = (state_q == SCAN);
    assign last_beat = scanning & sel_term;
    // in_ready is held low through a reset cycle and is combinational from out_ready
    assign in_ready  = rst_n & ((state_q == IDLE) | (last_beat & bus.out_ready));
    assign accept_in = bus.in_valid & in_ready;
    assign beat      = scanning & bus.out_ready;

    scan_sel_counter #(
        .N_IN      (N_IN),
        .SEL_W     (SEL_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_sel (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept_in),
        .en_i   (beat),
        .sel_o  (bus.mux_sel),
        .term_o (sel_term)
    );

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        if (accept_in) begin
            din_d = bus.in_data;
        end
        case (state_q)
            IDLE: if (accept_in) state_d = SCAN;
            SCAN: if (beat && last_beat && !accept_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mux_din   = din_q;
    assign bus.out_valid = scanning;
    assign bus.out_bit   = bus.mux_dout;
    assign bus.out_last  = last_beat;
    assign bus.busy      = scanning;

endmodule

// File: doc/mux_scan_feeder.md
Name: mux_scan_feeder

Overview:
- Upstream driver for the 4:1 bit mux (mux4x1): accepts a 4-bit word over a valid/ready handshake and presents it on the mux data input.
- Steps the mux select through all four positions, one per accepted beat, turning the word into a framed serial bit stream.
- Loops the mux output back in and forwards it downstream with valid/ready/last.
- The mux itself stays external, so the existing mux4x1 is reused unchanged.

Parameters:
- N_IN, 4, mux input count and word width. Fixed at 4 for mux4x1; kept symbolic for wider mux variants.
- SEL_W, 2, select width, equal to clog2(N_IN).
- MSB_FIRST, 0, scan order. 0: sel runs 0..N_IN-1. 1: sel runs N_IN-1..0.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  word available
- in_data  input  N_IN  word to serialise
- in_ready  output  1  block accepts in_data this cycle
- mux_din  output  N_IN  to mux4x1 din
- mux_sel  output  SEL_W  to mux4x1 sel
- mux_dout  input  1  from mux4x1 dout
- out_valid  output  1  out_bit is valid
- out_bit  output  1  serial bit, combinational pass of mux_dout
- out_last  output  1  final bit of the current word
- out_ready  input  1  downstream accepts the bit
- busy  output  1  a word is being scanned

Behaviour:
- Reset: synchronous active-low on clk. While rst_n=0 at an edge:
  - state goes to IDLE;
  - mux_din, mux_sel and the beat counter clear to 0;
  - in_ready=0 during the reset cycle, then 1 in IDLE;
  - out_valid=0, out_last=0, busy=0.
- Reset mid-scan aborts the word with no further beats and no out_last.
- State machine has two states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, register mux_din<=in_data, set mux_sel to the start index (0, or N_IN-1 if MSB_FIRST), go to SCAN.
  - SCAN: out_valid=1, busy=1, in_ready as defined below.
- Handshake in SCAN:
  - A beat is accepted when out_valid&out_ready. On each accept, mux_sel advances by one (+1, or -1 if MSB_FIRST).
  - When out_ready=0, mux_sel, mux_din and out_valid hold.
  - out_last=1 while out_valid and mux_sel equals the end index.
  - On accept with out_last=1: if in_valid, load the new word, reset mux_sel to the start index and stay in SCAN (zero-bubble back-to-back). Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==SCAN & out_last & out_ready). It is combinational from out_ready.
- Latency: first bit valid one cycle after the in_data accept. A word takes N_IN accepted beats. Sustained throughput is one bit per clock with out_ready held high.
- mux_din holds the last loaded word in IDLE; it does not clear until reset.
- mux_sel wraps only through the explicit reload, never by counter overflow.
- in_valid while busy and not at the last beat is ignored: in_ready=0, so the data is not consumed.
- out_bit depends on the external mux. The expected value is mux_din[mux_sel], and the bench checks against that.

Decomposition:
- Shared package holds:
  - state typedef {IDLE, SCAN};
  - start/end index constants derived from N_IN and MSB_FIRST;
  - N_IN and SEL_W defaults, reused by the mux benches.
- One natural sub-module: scan_sel_counter, a loadable up/down counter with enable and a terminal flag, producing mux_sel and out_last.
- The FSM and handshake stay in the top.

Test Plan:
1. Reset and single word, LSB first: hold rst_n=0 for 2 cycles, then load in_data=4'b0001 with out_ready=1.
   - Response: out_bit sequence 1,0,0,0 on sel 00,01,10,11; out_last only at sel=11; back to IDLE; in_ready=1.
2. Walking one: load 4'b0010, 4'b0100, 4'b1000 back-to-back with in_valid held.
   - Response: 12 consecutive valid beats, no bubble.
   - Each word produces a single 1 at the sel equal to its bit index.
   - in_ready pulses exactly at each last beat.
3. Backpressure: load 4'b1010 and drop out_ready on beat 2 for 3 cycles.
   - Response: mux_sel holds at 01 and out_bit holds at 1 during the stall.
   - Total output 0,1,0,1, with no beat lost or duplicated.
4. MSB_FIRST=1: load 4'b1100.
   - Response: sel 11,10,01,00 and bits 1,1,0,0; out_last at sel=00.
5. Mid-scan reset: load 4'b1111 and assert rst_n=0 after beat 2.
   - Response on the next cycle: out_valid=0, mux_sel=00, mux_din=0000, busy=0, and no out_last emitted.
6. Ignored input: while at beat 1 of 4'b0110, pulse in_valid with 4'b1001.
   - Response: in_ready=0 and the word is not consumed.
   - Output remains 0,1,1,0.
